// File: rtl/pipe_ctrl.sv
// pipe_ctrl: front-end pipeline stall/flush controller with RUN/TRAP/DRAIN FSM.
// Optional stage-0 stall counter enabled by macro PIPE_CTRL_PERF_EN.
`default_nettype none

module pipe_ctrl #(
  parameter int STAGES    = 6,
  parameter int FLUSH_CYC = 1
) (
  input  logic              Clk,
  input  logic              Rest,
  input  logic [STAGES-1:0] StallReq,
  input  logic [STAGES-1:0] FlushReq,
  input  logic              TrapReq,
  input  logic              Redir,
  output logic [STAGES-1:0] StallOut,
  output logic [STAGES-1:0] FlushOut,
  output logic              TrapPend,
  output logic [31:0]       StallCnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_TRAP  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [2:0] DRAIN_LOAD = (FLUSH_CYC > 1) ? 3'(FLUSH_CYC - 2) : 3'd0;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      state_q <= ST_RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Redir has priority in every state and discards any concurrent trap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (Redir) begin
      if (FLUSH_CYC > 1) begin
        state_d = ST_DRAIN;
        cnt_d   = DRAIN_LOAD;
      end else begin
        state_d = ST_RUN;
        cnt_d   = 3'd0;
      end
    end else begin
      case (state_q)
        ST_RUN:   if (TrapReq) state_d = ST_TRAP;
        ST_TRAP:  state_d = ST_TRAP;
        ST_DRAIN: begin
          if (cnt_q == 3'd0) state_d = ST_RUN;
          else               cnt_d   = cnt_q - 3'd1;
        end
        default:  state_d = ST_RUN;
      endcase
    end
  end

  logic [STAGES-1:0] raw_stall, raw_flush;
  logic              acc_s, acc_f;

  // Stall propagates from a stage toward younger stages; flush only hits younger ones.
  always_comb begin
    raw_stall = '0;
    raw_flush = '0;
    acc_s     = TrapReq | (state_q == ST_TRAP);
    acc_f     = Redir | (state_q == ST_DRAIN);
    for (int j = STAGES - 1; j >= 0; j--) begin
      acc_s        = acc_s | StallReq[j];
      raw_stall[j] = acc_s;
      raw_flush[j] = acc_f;
      acc_f        = acc_f | FlushReq[j];
    end
  end

  assign FlushOut = raw_flush;
  assign StallOut = raw_stall & ~raw_flush;
  assign TrapPend = (state_q == ST_TRAP);

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      stall_cnt_q <= 32'd0;
    end else if (StallOut[0] && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign StallCnt = stall_cnt_q;
`else
  assign StallCnt = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl (STAGES=6, FLUSH_CYC=2).
`default_nettype none

module tb_pipe_ctrl;

  localparam int STAGES    = 6;
  localparam int FLUSH_CYC = 2;
  localparam int M_RUN = 0, M_TRAP = 1, M_DRAIN = 2;

  logic              Clk = 1'b0;
  logic              Rest = 1'b0;
  logic [STAGES-1:0] StallReq = '0;
  logic [STAGES-1:0] FlushReq = '0;
  logic              TrapReq = 1'b0;
  logic              Redir = 1'b0;
  logic [STAGES-1:0] StallOut;
  logic [STAGES-1:0] FlushOut;
  logic              TrapPend;
  logic [31:0]       StallCnt;

  pipe_ctrl #(.STAGES(STAGES), .FLUSH_CYC(FLUSH_CYC)) dut (
    .Clk      (Clk),
    .Rest     (Rest),
    .StallReq (StallReq),
    .FlushReq (FlushReq),
    .TrapReq  (TrapReq),
    .Redir    (Redir),
    .StallOut (StallOut),
    .FlushOut (FlushOut),
    .TrapPend (TrapPend),
    .StallCnt (StallCnt)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [STAGES-1:0] stall;
    logic [STAGES-1:0] flush;
    logic              tp;
    logic [31:0]       cnt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  int          m_st = M_RUN;
  int          m_dc = 0;
  logic [31:0] m_pc = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic step(input logic rst, input logic [STAGES-1:0] sr,
                      input logic [STAGES-1:0] fr, input logic tr, input logic rd);
    exp_t e;
    exp_t o;
    @(posedge Clk);
    #1;
    Rest = rst; StallReq = sr; FlushReq = fr; TrapReq = tr; Redir = rd;
    if (!rst) begin
      m_st = M_RUN; m_dc = 0; m_pc = 32'd0;
    end
    for (int j = 0; j < STAGES; j++) begin
      e.flush[j] = ((fr >> (j + 1)) != 0) || rd || (m_st == M_DRAIN);
      e.stall[j] = (((sr >> j) != 0) || tr || (m_st == M_TRAP)) && !e.flush[j];
    end
    e.tp = (m_st == M_TRAP);
`ifdef PIPE_CTRL_PERF_EN
    e.cnt = m_pc;
`else
    e.cnt = 32'd0;
`endif
    sb.push_back(e);
    @(negedge Clk);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      o = sb.pop_front();
      chk("stall", 32'(StallOut), 32'(o.stall));
      chk("flush", 32'(FlushOut), 32'(o.flush));
      chk("trappend", 32'(TrapPend), 32'(o.tp));
      chk("stallcnt", StallCnt, o.cnt);
    end
    if (rst) begin
      if (e.stall[0] && m_pc != 32'hFFFF_FFFF) m_pc = m_pc + 32'd1;
      if (rd) begin
        m_st = (FLUSH_CYC > 1) ? M_DRAIN : M_RUN;
        m_dc = (FLUSH_CYC > 1) ? FLUSH_CYC - 2 : 0;
      end else if (m_st == M_RUN) begin
        if (tr) m_st = M_TRAP;
      end else if (m_st == M_DRAIN) begin
        if (m_dc == 0) m_st = M_RUN;
        else           m_dc = m_dc - 1;
      end
    end
  endtask

  initial begin
    // reset state, with active inputs still visible combinationally
    step(1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b0, 6'b000100, '0, 1'b0, 1'b0);
    chk("rst_comb_stall", 32'(StallOut), 32'h07);
    chk("rst_tp", 32'(TrapPend), 32'h0);

    // single-cycle stall at stage 3
    step(1'b1, 6'b001000, '0, 1'b0, 1'b0);
    chk("r29_stall", 32'(StallOut), 32'h0F);
    chk("r29_flush", 32'(FlushOut), 32'h00);
    step(1'b1, '0, '0, 1'b0, 1'b0);
    chk("r29_after", 32'(StallOut), 32'h00);

    // flush beats stall per stage
    step(1'b1, 6'b100000, 6'b000100, 1'b0, 1'b0);
    chk("r30_flush", 32'(FlushOut), 32'h03);
    chk("r30_stall", 32'(StallOut), 32'h3C);

    // trap held then redirected
    step(1'b1, '0, '0, 1'b1, 1'b0);
    chk("r31_c0_stall", 32'(StallOut), 32'h3F);
    step(1'b1, '0, '0, 1'b0, 1'b0);
    chk("r31_c1_tp", 32'(TrapPend), 32'h1);
    step(1'b1, '0, '0, 1'b0, 1'b0);
    step(1'b1, '0, '0, 1'b0, 1'b1);
    chk("r31_n_flush", 32'(FlushOut), 32'h3F);
    chk("r31_n_stall", 32'(StallOut), 32'h00);
    step(1'b1, '0, '0, 1'b0, 1'b0);
    chk("r31_n1_flush", 32'(FlushOut), 32'h3F);
    chk("r31_n1_tp", 32'(TrapPend), 32'h0);
    step(1'b1, '0, '0, 1'b0, 1'b0);
    chk("r31_n2_flush", 32'(FlushOut), 32'h00);

    // simultaneous trap and redirect
    step(1'b1, '0, '0, 1'b1, 1'b1);
    step(1'b1, '0, '0, 1'b0, 1'b0);
    chk("r32_tp", 32'(TrapPend), 32'h0);
    chk("r32_flush2", 32'(FlushOut), 32'h3F);
    step(1'b1, '0, '0, 1'b0, 1'b0);

    // redirect inside DRAIN reloads; trap inside DRAIN ignored
    step(1'b1, '0, '0, 1'b0, 1'b1);
    step(1'b1, '0, '0, 1'b1, 1'b1);
    step(1'b1, '0, '0, 1'b1, 1'b0);
    step(1'b1, '0, '0, 1'b0, 1'b0);
    chk("drain_trap_ignored", 32'(TrapPend), 32'h0);

    // reset aborts TRAP
    step(1'b1, '0, '0, 1'b1, 1'b0);
    step(1'b1, '0, '0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("r33_tp", 32'(TrapPend), 32'h0);
    chk("r33_stall", 32'(StallOut), 32'h00);
    step(1'b1, '0, '0, 1'b0, 1'b0);
    step(1'b1, '0, '0, 1'b0, 1'b0);

    // five stall cycles on stage 0
    for (int i = 0; i < 5; i++) step(1'b1, 6'b000001, '0, 1'b0, 1'b0);
    step(1'b1, '0, '0, 1'b0, 1'b0);
`ifdef PIPE_CTRL_PERF_EN
    chk("r34_cnt5", StallCnt, 32'd5);
`else
    chk("r34_cnt0", StallCnt, 32'd0);
`endif

    // random traffic
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 39) != 0),
           (($urandom_range(0, 2) == 0) ? STAGES'($urandom) : '0),
           (($urandom_range(0, 3) == 0) ? STAGES'($urandom) : '0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 11) == 0));
    end

    if (sb.size() != 0) chk("sb_leftover", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter STAGES, default 6: number of front-end pipeline stages controlled; stage 0 is PC (youngest), stage STAGES-1 is oldest (FTQ); legal 2..16.
REQ-002 Parameter FLUSH_CYC, default 1: cycles a redirect flush is asserted, counting the Redir cycle; legal 1..8.
REQ-003 Clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Rest  input  1  reset, asynchronous, active-low.
REQ-005 StallReq  input  STAGES  per-stage stall request (cache miss, queue full, ...).
REQ-006 FlushReq  input  STAGES  per-stage local flush request (e.g. predecode mispredict).
REQ-007 TrapReq  input  1  front-end fault pulse; front end holds until redirect.
REQ-008 Redir  input  1  back-end (ROB) redirect pulse.
REQ-009 StallOut  output  STAGES  per-stage stall enable.
REQ-010 FlushOut  output  STAGES  per-stage flush enable.
REQ-011 TrapPend  output  1  high while in TRAP state.
REQ-012 StallCnt  output  32  stage-0 stall cycle counter (present only per REQ-028).

Function
REQ-013 The block SHALL implement states RUN, TRAP, DRAIN in a registered state machine.
REQ-014 RUN->TRAP when TrapReq=1 and Redir=0; TRAP holds until Redir=1.
REQ-015 Redir=1 in any state SHALL go to DRAIN if FLUSH_CYC>1 (counter loaded FLUSH_CYC-2), else RUN; Redir wins over simultaneous TrapReq, and the trap is dropped.
REQ-016 DRAIN decrements its counter each cycle and returns to RUN after counter 0; Redir in DRAIN reloads the counter; TrapReq in DRAIN is ignored.
REQ-017 Raw stall for stage j = OR of StallReq[k] for k>=j, OR TrapReq, OR state==TRAP (combinational, zero latency).
REQ-018 Raw flush for stage j = OR of FlushReq[k] for k>j (a stage never flushes itself on its own request), OR Redir, OR state==DRAIN.
REQ-019 FlushOut[j] = raw flush for stage j; StallOut[j] = raw stall AND NOT FlushOut[j] (flush beats stall per stage).
REQ-020 FlushReq[0] and StallReq bits for stages flushed in the same cycle SHALL have no other effect.
REQ-021 TrapPend = (state==TRAP), registered, no combinational input path.
REQ-022 With all inputs low in RUN, StallOut=0 and FlushOut=0.
REQ-023 X on any input while Rest=0 SHALL NOT propagate to state.

Reset
REQ-024 Rest=0 SHALL asynchronously force state RUN, DRAIN counter 0, TrapPend 0, StallCnt 0.
REQ-025 During reset StallOut and FlushOut reflect only the combinational input terms (REQ-017/018 with state RUN).
REQ-026 Reset asserted mid-TRAP or mid-DRAIN SHALL abort it; first cycle after release is RUN.

Configuration
REQ-027 Macro PIPE_CTRL_PERF_EN selects the performance counter.
REQ-028 Defined: StallCnt increments by 1 on each cycle StallOut[0]=1, saturating at 32'hFFFF_FFFF. Undefined: StallCnt port tied to 0, no counter flops synthesized; all other behaviour identical.

Verification (STAGES=6, FLUSH_CYC=2 unless noted)
REQ-029 StallReq=6'b001000 one cycle -> StallOut=6'b001111 same cycle, FlushOut=0, next cycle StallOut=0.
REQ-030 StallReq=6'b100000 and FlushReq=6'b000100 together -> FlushOut=6'b000011, StallOut=6'b111100.
REQ-031 TrapReq pulse at cycle 0 -> StallOut=6'b111111 cycles 0..N, TrapPend=1 from cycle 1; Redir at cycle N -> FlushOut=6'b111111 cycles N and N+1, StallOut=0, TrapPend=0 from N+1, RUN at N+2.
REQ-032 TrapReq and Redir same cycle -> FlushOut=6'b111111 two cycles, TrapPend stays 0.
REQ-033 Rest pulled low during TRAP -> TrapPend=0 immediately, StallOut=0 with inputs low; after release, StallReq=0 keeps outputs 0.
REQ-034 With PIPE_CTRL_PERF_EN: 5 stall cycles on stage 0 -> StallCnt=5; counter preloaded near max holds 32'hFFFF_FFFF; without macro StallCnt=0 always.
